// File: rtl/reg_file.sv
// Architectural register file with per-register rename tags.
// Each register holds its committed value and the ROB index of its youngest
// in-flight producer (tag 0 = value is valid). Commits arrive from the ROB;
// decode reads operands and renames destinations here.
module reg_file #(
  parameter int ROB_BIT = 4,
  parameter int REG_NUM = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rob_rb_ena,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  output logic [ROB_BIT-1:0] id_rs1_tag,
  output logic [ROB_BIT-1:0] id_rs2_tag,
  output logic [31:0]        id_rs1_val,
  output logic [31:0]        id_rs2_val,
  input  logic               id_rn_ena,
  input  logic [4:0]         id_rn_rd,
  input  logic [ROB_BIT-1:0] id_rn_idx,
  input  logic               reg_wr_ena,
  input  logic [4:0]         reg_wr_rd,
  input  logic [31:0]        reg_wr_val,
  input  logic [ROB_BIT-1:0] reg_wr_idx
);

  logic [31:0]        val [REG_NUM];
  logic [ROB_BIT-1:0] tag [REG_NUM];

  logic commit_ok;
  logic rename_ok;

  // Qualify commit and rename once; x0 is never written, rename needs rdy and no rollback
  always_comb begin
    commit_ok = reg_wr_ena && (reg_wr_rd != 5'd0);
    rename_ok = rdy && id_rn_ena && (id_rn_rd != 5'd0) && !rob_rb_ena;
  end

  // Value and tag update: commit writes value, rename overrides the tag clear, rollback clears all tags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        val[i] <= '0;
        tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REG_NUM; i++) begin
        if (commit_ok && (reg_wr_rd == 5'(i))) begin
          val[i] <= reg_wr_val;
        end
        if (rob_rb_ena) begin
          tag[i] <= '0;
        end else if (rename_ok && (id_rn_rd == 5'(i))) begin
          tag[i] <= id_rn_idx;
        end else if (commit_ok && (reg_wr_rd == 5'(i)) && (tag[i] == reg_wr_idx)) begin
          tag[i] <= '0;
        end
      end
    end
  end

  // Source 1 read with same-cycle commit bypass when the committing entry is the current producer
  always_comb begin
    id_rs1_tag = '0;
    id_rs1_val = '0;
    if (!rst && (id_rs1 != 5'd0)) begin
      if (reg_wr_ena && (reg_wr_rd == id_rs1) && (tag[id_rs1] == reg_wr_idx)) begin
        id_rs1_val = reg_wr_val;
      end else begin
        id_rs1_tag = tag[id_rs1];
        id_rs1_val = val[id_rs1];
      end
    end
  end

  // Source 2 read, same bypass rule as source 1
  always_comb begin
    id_rs2_tag = '0;
    id_rs2_val = '0;
    if (!rst && (id_rs2 != 5'd0)) begin
      if (reg_wr_ena && (reg_wr_rd == id_rs2) && (tag[id_rs2] == reg_wr_idx)) begin
        id_rs2_val = reg_wr_val;
      end else begin
        id_rs2_tag = tag[id_rs2];
        id_rs2_val = val[id_rs2];
      end
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed testbench for reg_file: expected read results are queued when the
// read is set up and compared when the combinational outputs have settled.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        rob_rb_ena;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [3:0]  id_rs1_tag;
  logic [3:0]  id_rs2_tag;
  logic [31:0] id_rs1_val;
  logic [31:0] id_rs2_val;
  logic        id_rn_ena;
  logic [4:0]  id_rn_rd;
  logic [3:0]  id_rn_idx;
  logic        reg_wr_ena;
  logic [4:0]  reg_wr_rd;
  logic [31:0] reg_wr_val;
  logic [3:0]  reg_wr_idx;

  typedef struct {
    string       name;
    logic [3:0]  t1;
    logic [31:0] v1;
    logic [3:0]  t2;
    logic [31:0] v2;
  } exp_t;

  exp_t exp_q[$];
  int total;
  int bad;

  reg_file #(.ROB_BIT(4), .REG_NUM(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .rob_rb_ena (rob_rb_ena),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rs1_tag (id_rs1_tag),
    .id_rs2_tag (id_rs2_tag),
    .id_rs1_val (id_rs1_val),
    .id_rs2_val (id_rs2_val),
    .id_rn_ena  (id_rn_ena),
    .id_rn_rd   (id_rn_rd),
    .id_rn_idx  (id_rn_idx),
    .reg_wr_ena (reg_wr_ena),
    .reg_wr_rd  (reg_wr_rd),
    .reg_wr_val (reg_wr_val),
    .reg_wr_idx (reg_wr_idx)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive all control inputs for the coming clock edge
  task automatic applyStimulus(input logic rb, input logic rn_en, input logic [4:0] rn_rd,
                               input logic [3:0] rn_idx, input logic wr_en, input logic [4:0] wr_rd,
                               input logic [31:0] wr_val, input logic [3:0] wr_idx);
    rob_rb_ena = rb;
    id_rn_ena  = rn_en;
    id_rn_rd   = rn_rd;
    id_rn_idx  = rn_idx;
    reg_wr_ena = wr_en;
    reg_wr_rd  = wr_rd;
    reg_wr_val = wr_val;
    reg_wr_idx = wr_idx;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Select read ports and push the expected outputs onto the scoreboard
  task automatic expectRead(input string name, input logic [4:0] rs1, input logic [3:0] t1,
                            input logic [31:0] v1, input logic [4:0] rs2, input logic [3:0] t2,
                            input logic [31:0] v2);
    exp_t e;
    id_rs1 = rs1;
    id_rs2 = rs2;
    e.name = name;
    e.t1 = t1;
    e.v1 = v1;
    e.t2 = t2;
    e.v2 = v2;
    exp_q.push_back(e);
  endtask

  task automatic cmp(input string name, input string field, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s %s got=%0h want=%0h", name, field, got, want);
    end
  endtask

  // Let combinational outputs settle mid-cycle, then pop and compare
  task automatic checkOutput();
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("[TB] FAIL scoreboard got=empty want=entry");
    end else begin
      e = exp_q.pop_front();
      cmp(e.name, "rs1_tag", 32'(id_rs1_tag), 32'(e.t1));
      cmp(e.name, "rs1_val", id_rs1_val, e.v1);
      cmp(e.name, "rs2_tag", 32'(id_rs2_tag), 32'(e.t2));
      cmp(e.name, "rs2_val", id_rs2_val, e.v2);
    end
  endtask

  // Directed sequence following the test plan
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    rdy = 1'b1;
    idle();
    id_rs1 = 5'd0;
    id_rs2 = 5'd0;

    // Reset held: outputs zero even with a commit pending on the inputs
    #1;
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'hCAFE, 4'd0);
    expectRead("in_reset", 5'd5, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0);
    checkOutput();
    idle();
    step();
    rst = 1'b0;

    expectRead("after_reset", 5'd5, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0);
    checkOutput();

    // x0 commit ignored, including the same-cycle bypass
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd0, 32'hDEAD, 4'd0);
    expectRead("x0_commit_same", 5'd0, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0);
    checkOutput();
    step();
    idle();
    expectRead("x0_commit_next", 5'd0, 4'd0, 32'd0, 5'd5, 4'd0, 32'd0);
    checkOutput();

    // Rename x3 -> 4: invisible this cycle, visible next
    applyStimulus(1'b0, 1'b1, 5'd3, 4'd4, 1'b0, 5'd0, 32'd0, 4'd0);
    expectRead("rn_x3_same", 5'd3, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0);
    checkOutput();
    step();
    idle();
    expectRead("rn_x3_next", 5'd3, 4'd4, 32'd0, 5'd0, 4'd0, 32'd0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd3, 32'h1234, 4'd4);
    expectRead("x3_bypass", 5'd3, 4'd0, 32'h1234, 5'd3, 4'd0, 32'h1234);
    checkOutput();
    step();
    idle();
    expectRead("x3_after", 5'd3, 4'd0, 32'h1234, 5'd0, 4'd0, 32'd0);
    checkOutput();

    // Stale commit to x7: value written, younger tag kept, no bypass
    applyStimulus(1'b0, 1'b1, 5'd7, 4'd2, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd7, 4'd5, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 32'hAA, 4'd2);
    expectRead("x7_stale_same", 5'd7, 4'd5, 32'd0, 5'd0, 4'd0, 32'd0);
    checkOutput();
    step();
    idle();
    expectRead("x7_stale_next", 5'd7, 4'd5, 32'hAA, 5'd0, 4'd0, 32'd0);
    checkOutput();

    // Commit and rename on x9 together: rename wins the tag
    applyStimulus(1'b0, 1'b1, 5'd9, 4'd3, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd9, 4'd6, 1'b1, 5'd9, 32'h55, 4'd3);
    expectRead("x9_both_same", 5'd9, 4'd0, 32'h55, 5'd0, 4'd0, 32'd0);
    checkOutput();
    step();
    idle();
    expectRead("x9_both_next", 5'd9, 4'd6, 32'h55, 5'd0, 4'd0, 32'd0);
    checkOutput();

    // Rollback with a commit and a rename in the same cycle
    applyStimulus(1'b0, 1'b1, 5'd1, 4'd2, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd2, 4'd3, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    applyStimulus(1'b0, 1'b1, 5'd4, 4'd7, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    idle();
    expectRead("pre_rb", 5'd1, 4'd2, 32'd0, 5'd4, 4'd7, 32'd0);
    checkOutput();
    applyStimulus(1'b1, 1'b1, 5'd8, 4'd9, 1'b1, 5'd1, 32'h10, 4'd2);
    expectRead("rb_same", 5'd1, 4'd0, 32'h10, 5'd4, 4'd7, 32'd0);
    checkOutput();
    step();
    idle();
    expectRead("rb_x1_x4", 5'd1, 4'd0, 32'h10, 5'd4, 4'd0, 32'd0);
    checkOutput();
    step();
    expectRead("rb_x2_x8", 5'd2, 4'd0, 32'd0, 5'd8, 4'd0, 32'd0);
    checkOutput();
    step();
    expectRead("rb_keep_vals", 5'd3, 4'd0, 32'h1234, 5'd9, 4'd0, 32'h55);
    checkOutput();
    step();
    expectRead("rb_x7", 5'd7, 4'd0, 32'hAA, 5'd0, 4'd0, 32'd0);
    checkOutput();

    // rdy low: rename dropped, commit still applied
    rdy = 1'b0;
    applyStimulus(1'b0, 1'b1, 5'd6, 4'd3, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    idle();
    expectRead("rdy_rn_drop", 5'd6, 4'd0, 32'd0, 5'd0, 4'd0, 32'd0);
    checkOutput();
    applyStimulus(1'b0, 1'b0, 5'd0, 4'd0, 1'b1, 5'd6, 32'h77, 4'd1);
    step();
    idle();
    expectRead("rdy_commit", 5'd6, 4'd0, 32'h77, 5'd9, 4'd0, 32'h55);
    checkOutput();
    rdy = 1'b1;
    applyStimulus(1'b0, 1'b1, 5'd6, 4'd5, 1'b0, 5'd0, 32'd0, 4'd0);
    step();
    idle();
    expectRead("pre_async_rst", 5'd6, 4'd5, 32'h77, 5'd3, 4'd0, 32'h1234);
    checkOutput();

    // Asynchronous reset between edges clears everything immediately
    step();
    rst = 1'b1;
    expectRead("async_rst", 5'd6, 4'd0, 32'd0, 5'd3, 4'd0, 32'd0);
    checkOutput();
    step();
    rst = 1'b0;
    expectRead("post_rst", 5'd6, 4'd0, 32'd0, 5'd9, 4'd0, 32'd0);
    checkOutput();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
